// File: rtl/mem_arbiter.sv
// Two-requester arbiter (data ld/st and instruction fetch) in front of a single-port memory.
// Data wins unless a fetch has been kept waiting for STARVE consecutive data grants.
module mem_arbiter #(
  parameter int STARVE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  localparam logic [2:0] STARVE_L = 3'(STARVE);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_starve_cnt;
  logic [2:0]  w_starve_nxt;
  logic        r_mem_req;
  logic        r_mem_we;
  logic        w_mem_we_nxt;
  logic [15:0] r_mem_addr;
  logic [15:0] w_mem_addr_nxt;
  logic [15:0] r_mem_wdata;
  logic [15:0] w_mem_wdata_nxt;
  logic        r_d_done;
  logic        w_d_done_nxt;
  logic        r_i_done;
  logic        w_i_done_nxt;
  logic [15:0] r_d_rdata;
  logic [15:0] w_d_rdata_nxt;
  logic [15:0] r_i_rdata;
  logic [15:0] w_i_rdata_nxt;
  logic        r_busy;
  logic        w_grant_d;
  logic        w_grant_i;

  // A pending fetch only blocks data once the starvation budget is spent.
  assign w_grant_d = (r_state == IDLE) && d_req && (!i_req || (r_starve_cnt < STARVE_L));
  assign w_grant_i = (r_state == IDLE) && i_req && !w_grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= 3'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 16'h0000;
      r_mem_wdata  <= 16'h0000;
      r_d_done     <= 1'b0;
      r_i_done     <= 1'b0;
      r_d_rdata    <= 16'h0000;
      r_i_rdata    <= 16'h0000;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_mem_req    <= (w_state_nxt != IDLE);
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_d_done     <= w_d_done_nxt;
      r_i_done     <= w_i_done_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
      r_i_rdata    <= w_i_rdata_nxt;
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d)      w_state_nxt = DATA;
        else if (w_grant_i) w_state_nxt = FETCH;
      end
      DATA:    if (mem_ack) w_state_nxt = IDLE;
      FETCH:   if (mem_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output; the transaction fields only load on a grant.
  always_comb begin
    w_starve_nxt    = r_starve_cnt;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_d_done_nxt    = 1'b0;
    w_i_done_nxt    = 1'b0;
    w_d_rdata_nxt   = r_d_rdata;
    w_i_rdata_nxt   = r_i_rdata;
    if (w_grant_d) begin
      w_mem_we_nxt    = d_we;
      w_mem_addr_nxt  = d_addr;
      w_mem_wdata_nxt = d_wdata;
      w_starve_nxt    = i_req ? (r_starve_cnt + 3'd1) : 3'd0;
    end else if (w_grant_i) begin
      w_mem_we_nxt   = 1'b0;
      w_mem_addr_nxt = i_addr;
      w_starve_nxt   = 3'd0;
    end
    if ((r_state == DATA) && mem_ack) begin
      w_d_done_nxt = 1'b1;
      if (!r_mem_we) w_d_rdata_nxt = mem_rdata;
    end
    if ((r_state == FETCH) && mem_ack) begin
      w_i_done_nxt  = 1'b1;
      w_i_rdata_nxt = mem_rdata;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign d_done    = r_d_done;
  assign i_done    = r_i_done;
  assign d_rdata   = r_d_rdata;
  assign i_rdata   = r_i_rdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model with programmable wait states,
// grant and completion queues filled by the stimulus, checked by negedge monitors.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [15:0] d_addr = '0, d_wdata = '0;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.STARVE(4)) dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic we; logic [15:0] wdata; } grant_t;
  typedef struct { logic is_i; logic [15:0] rdata; } done_t;
  grant_t grant_q[$];
  done_t  done_q[$];

  logic [15:0] mem [0:255];
  int          waits = 0;
  int          wcnt = 0;
  logic        ack_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: answers after 'waits' stall cycles, ack only meaningful while mem_req=1.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = ack_force;
      wcnt = 0;
    end else if (wcnt == waits) begin
      mem_ack = 1'b1;
      mem_rdata = mem[mem_addr[7:0]];
      if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
      wcnt = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  end

  logic        prev_req = 1'b0;
  grant_t      cur;

  always @(negedge clk) begin
    if (mem_req === 1'b1 && !prev_req) begin
      if (grant_q.size() == 0) begin
        check("unexpected_grant", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        cur = grant_q.pop_front();
        check("grant_addr", 32'(mem_addr), 32'(cur.addr));
        check("grant_we", 32'(mem_we), 32'(cur.we));
        if (cur.we) check("grant_wdata", 32'(mem_wdata), 32'(cur.wdata));
        cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata;
      end
    end else if (mem_req === 1'b1 && prev_req) begin
      check("stable_addr", 32'(mem_addr), 32'(cur.addr));
      check("stable_we", 32'(mem_we), 32'(cur.we));
      check("stable_wdata", 32'(mem_wdata), 32'(cur.wdata));
    end
    prev_req = (mem_req === 1'b1);
  end

  done_t exp_d;
  always @(negedge clk) begin
    if (d_done === 1'b1 || i_done === 1'b1) begin
      check("done_exclusive", 32'(d_done & i_done), 32'd0);
      if (done_q.size() == 0) begin
        check("unexpected_done", {30'd0, d_done, i_done}, 32'd0);
      end else begin
        exp_d = done_q.pop_front();
        check("done_kind", 32'(i_done), 32'(exp_d.is_i));
        check("done_rdata", 32'(exp_d.is_i ? i_rdata : d_rdata), 32'(exp_d.rdata));
      end
    end
  end

  task automatic push_grant(input logic [15:0] a, input logic we, input logic [15:0] wd);
    grant_t g;
    g.addr = a; g.we = we; g.wdata = wd;
    grant_q.push_back(g);
  endtask

  task automatic push_done(input logic is_i, input logic [15:0] rd);
    done_t d;
    d.is_i = is_i; d.rdata = rd;
    done_q.push_back(d);
  endtask

  // Counts rising edges until the selected done pulse is seen; 0 on timeout.
  task automatic wait_done(input logic want_i, output int n);
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if ((want_i ? i_done : d_done) === 1'b1) begin
        n = k;
        return;
      end
    end
    check("wait_done_timeout", 32'd0, 32'd1);
  endtask

  int n1, n2, seen;

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'(k * 3 + 16'h0A00);
    mem[8'h10] = 16'hBEEF;
    mem[8'h40] = 16'h4A4A;
    mem[8'h60] = 16'h6C6C;
    mem[8'h80] = 16'hCAFE;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_done", {30'd0, d_done, i_done}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", {d_rdata, i_rdata}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // single read, zero wait
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    push_grant(16'h0010, 1'b0, 16'h0); push_done(1'b0, 16'hBEEF);
    @(posedge clk); #1;
    check("read_c1_mem_req", 32'(mem_req), 32'd1);
    check("read_c1_addr", 32'(mem_addr), 32'h0010);
    @(posedge clk); #1;
    check("read_c2_done", 32'(d_done), 32'd1);
    check("read_c2_busy", 32'(busy), 32'd0);
    check("read_c2_rdata", 32'(d_rdata), 32'hBEEF);
    d_req = 1'b0;

    // write: d_rdata must keep 0xBEEF
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    push_grant(16'h0020, 1'b1, 16'h1234); push_done(1'b0, 16'hBEEF);
    wait_done(1'b0, n1);
    d_req = 1'b0; d_we = 1'b0;
    check("write_latency", 32'(n1), 32'd2);
    check("write_mem", 32'(mem[8'h20]), 32'h1234);

    // simultaneous requests: data first, then fetch
    @(negedge clk);
    d_req = 1'b1; d_addr = 16'h0030; i_req = 1'b1; i_addr = 16'h0040;
    push_grant(16'h0030, 1'b0, 16'h0); push_done(1'b0, mem[8'h30]);
    push_grant(16'h0040, 1'b0, 16'h0); push_done(1'b1, 16'h4A4A);
    wait_done(1'b0, n1);
    d_req = 1'b0;
    wait_done(1'b1, n2);
    i_req = 1'b0;
    check("simul_d_latency", 32'(n1), 32'd2);
    check("simul_i_latency", 32'(n1 + n2), 32'd4);
    check("simul_i_rdata", 32'(i_rdata), 32'h4A4A);

    // wait states: ack after 3 stall cycles, requester inputs change mid-transaction
    waits = 3;
    @(negedge clk);
    d_req = 1'b1; d_addr = 16'h0080;
    push_grant(16'h0080, 1'b0, 16'h0); push_done(1'b0, 16'hCAFE);
    @(posedge clk); #1;
    d_addr = 16'h0090; d_we = 1'b1;
    wait_done(1'b0, n1);
    d_req = 1'b0; d_we = 1'b0;
    check("wait_latency", 32'(n1 + 1), 32'd5);
    waits = 0;

    // mem_ack while idle is ignored
    @(negedge clk);
    ack_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_done", {30'd0, d_done, i_done}, 32'd0);
    @(negedge clk) ack_force = 1'b0;

    // starvation: both held for 10 transactions
    @(negedge clk);
    d_req = 1'b1; d_addr = 16'h0050; i_req = 1'b1; i_addr = 16'h0060;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push_grant(16'h0050, 1'b0, 16'h0); push_done(1'b0, mem[8'h50]);
      end
      push_grant(16'h0060, 1'b0, 16'h0); push_done(1'b1, 16'h6C6C);
    end
    seen = 0;
    for (int k = 0; k < 200 && seen < 10; k++) begin
      @(posedge clk); #1;
      if (d_done === 1'b1 || i_done === 1'b1) seen++;
    end
    d_req = 1'b0; i_req = 1'b0;
    check("starve_count", 32'(seen), 32'd10);

    // reset in the ack cycle abandons the transaction
    @(negedge clk);
    d_req = 1'b1; d_addr = 16'h0070;
    push_grant(16'h0070, 1'b0, 16'h0);
    @(posedge clk); #1;
    reset = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", {30'd0, d_done, i_done}, 32'd0);
    check("rst_mid_rdata", 32'(d_rdata), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_addr = 16'h0010; i_req = 1'b1; i_addr = 16'h0040;
    for (int k = 0; k < 4; k++) begin
      push_grant(16'h0010, 1'b0, 16'h0); push_done(1'b0, 16'hBEEF);
    end
    push_grant(16'h0040, 1'b0, 16'h0); push_done(1'b1, 16'h4A4A);
    wait_done(1'b0, n1);
    check("post_rst_latency", 32'(n1), 32'd2);
    seen = 1;
    for (int k = 0; k < 100 && seen < 5; k++) begin
      @(posedge clk); #1;
      if (d_done === 1'b1 || i_done === 1'b1) seen++;
    end
    d_req = 1'b0; i_req = 1'b0;
    check("post_rst_count", 32'(seen), 32'd5);

    repeat (4) @(posedge clk);
    #1;
    check("grant_q_empty", 32'(grant_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
